window_vote_detector: RTL and testbench

- Parametrised successor to the team's 3-bit "at least two of three in range" voter.
- Accepts NCH unsigned WIDTH-bit samples per beat and compares each against a runtime window [lo, hi].
- Counts in-window channels and flags a hit when count >= min_votes.
- A persistence FSM raises alarm only after PERSIST consecutive hit beats.
- Two-stage pipeline with valid qualification; sits between sensor sample capture and alarm/IRQ logic.

---
 rtl/wvd_pkg.sv | 13 +
 rtl/window_vote_detector_if.sv | 30 +++
 rtl/window_cmp.sv | 11 +
 rtl/window_vote_detector.sv | 61 ++++++
 tb/tb_window_vote_detector.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/wvd_pkg.sv
// wvd_pkg: shared FSM state type and counting helpers for window_vote_detector
package wvd_pkg;
  localparam int MAXN = 64;
  typedef enum logic [1:0] {IDLE, ARMING, ALARM} wvd_state_e;
  function automatic int clog2_cnt(int n);
    return $clog2(n + 1);
  endfunction
  function automatic int popcount(logic [MAXN-1:0] v);
    int n = 0;
    for (int i = 0; i < MAXN; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/window_vote_detector_if.sv
// window_vote_detector_if: sample beat in, vote result out
//   master: drives in_valid/in_data/lo/hi/min_votes, observes results
//   slave : the detector, drives out_valid/match_mask/hit_count/hit/alarm/persist_cnt
interface window_vote_detector_if #(
  parameter int WIDTH = 3,
  parameter int NCH = 3,
  parameter int PERSIST = 4
) ();
  localparam int CW = wvd_pkg::clog2_cnt(NCH);
  localparam int PW = wvd_pkg::clog2_cnt(PERSIST);
  logic in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [CW-1:0] min_votes;
  logic out_valid;
  logic [NCH-1:0] match_mask;
  logic [CW-1:0] hit_count;
  logic hit;
  logic alarm;
  logic [PW-1:0] persist_cnt;
  modport master (
    output in_valid, in_data, lo, hi, min_votes,
    input out_valid, match_mask, hit_count, hit, alarm, persist_cnt
  );
  modport slave (
    input in_valid, in_data, lo, hi, min_votes,
    output out_valid, match_mask, hit_count, hit, alarm, persist_cnt
  );
endinterface

// File: rtl/window_cmp.sv
// window_cmp: unsigned inclusive range check, m = lo <= x <= hi (ports x, lo, hi -> m)
module window_cmp #(
  parameter int WIDTH = 3
) (
  input logic [WIDTH-1:0] x,
  input logic [WIDTH-1:0] lo,
  input logic [WIDTH-1:0] hi,
  output logic m
);
  assign m = (lo <= x) && (x <= hi);
endmodule

// File: rtl/window_vote_detector.sv
// window_vote_detector: NCH-channel window vote, 2-stage pipeline, persistence alarm
//   clk, rst_n (async assert, active low); bus: slave side of window_vote_detector_if
module window_vote_detector import wvd_pkg::*; #(
  parameter int WIDTH = 3,
  parameter int NCH = 3,
  parameter int PERSIST = 4
) (
  input logic clk,
  input logic rst_n,
  window_vote_detector_if.slave bus
);
  localparam int CW = clog2_cnt(NCH);
  localparam int PW = clog2_cnt(PERSIST);
  logic [NCH-1:0] m, m_q;
  logic [CW-1:0] mv_q, pc;
  logic v1, hit_d;
  logic [PW-1:0] cnt_up;
  wvd_state_e st;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    window_cmp #(.WIDTH(WIDTH)) u_cmp (
      .x(bus.in_data[i*WIDTH +: WIDTH]),
      .lo(bus.lo),
      .hi(bus.hi),
      .m(m[i])
    );
  end
  assign pc = CW'(popcount(MAXN'(m_q)));
  assign hit_d = pc >= mv_q;
  // ALARM saturates; in IDLE/ARMING the count is below PERSIST so +1 cannot overflow
  assign cnt_up = (st == ALARM) ? bus.persist_cnt : bus.persist_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      mv_q <= '0;
      v1 <= 1'b0;
      st <= IDLE;
      bus.out_valid <= 1'b0;
      bus.match_mask <= '0;
      bus.hit_count <= '0;
      bus.hit <= 1'b0;
      bus.alarm <= 1'b0;
      bus.persist_cnt <= '0;
    end else begin
      v1 <= bus.in_valid;
      bus.out_valid <= v1;
      if (bus.in_valid) begin
        m_q <= m;
        mv_q <= bus.min_votes;
      end
      // result fields and FSM move only on beats leaving stage 2; gaps hold everything
      if (v1) begin
        bus.match_mask <= m_q;
        bus.hit_count <= pc;
        bus.hit <= hit_d;
        bus.persist_cnt <= hit_d ? cnt_up : '0;
        st <= !hit_d ? IDLE : (cnt_up == PW'(PERSIST)) ? ALARM : ARMING;
        bus.alarm <= hit_d && (cnt_up == PW'(PERSIST));
      end
    end
  end
endmodule

// File: tb/tb_window_vote_detector.sv
// tb_window_vote_detector: directed vectors, per-cycle model compare plus literal pins
module tb_window_vote_detector;
  localparam int W = 3, N = 3, P = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  window_vote_detector_if #(.WIDTH(W), .NCH(N), .PERSIST(P)) b1 ();
  window_vote_detector_if #(.WIDTH(8), .NCH(5), .PERSIST(2)) b2 ();
  window_vote_detector #(.WIDTH(W), .NCH(N), .PERSIST(P)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  window_vote_detector #(.WIDTH(8), .NCH(5), .PERSIST(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  int tests = 0;
  int fails = 0;
  typedef struct {logic [2:0] mask; int cnt; logic hit;} res_t;
  res_t q[$];
  res_t r;
  logic pend = 1'b0, e_ov = 1'b0, e_hit = 1'b0, e_alarm = 1'b0;
  logic [2:0] e_mask = '0;
  int e_cnt = 0, run = 0;
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic res_t score(logic [8:0] d, logic [2:0] l, logic [2:0] h, logic [1:0] mv);
    res_t s;
    s.mask = '0;
    s.cnt = 0;
    for (int c = 0; c < 3; c++) begin
      logic [2:0] x;
      x = d[c*3 +: 3];
      s.mask[c] = (x >= l) && (x <= h);
      s.cnt += int'(s.mask[c]);
    end
    s.hit = s.cnt >= int'(mv);
    return s;
  endfunction
  // reference: each accepted beat surfaces 2 edges later; alarm = run of PERSIST hit results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pend = 1'b0;
      e_ov = 1'b0;
      e_mask = '0;
      e_cnt = 0;
      e_hit = 1'b0;
      run = 0;
      e_alarm = 1'b0;
    end else begin
      e_ov = pend;
      if (pend) begin
        r = q.pop_front();
        e_mask = r.mask;
        e_cnt = r.cnt;
        e_hit = r.hit;
        run = r.hit ? ((run < P) ? run + 1 : P) : 0;
        e_alarm = (run == P);
      end
      pend = b1.in_valid;
      if (b1.in_valid) q.push_back(score(b1.in_data, b1.lo, b1.hi, b1.min_votes));
    end
  end
  always @(negedge clk) begin
    check("out_valid", 32'(b1.out_valid), 32'(e_ov));
    check("match_mask", 32'(b1.match_mask), 32'(e_mask));
    check("hit_count", 32'(b1.hit_count), 32'(e_cnt));
    check("hit", 32'(b1.hit), 32'(e_hit));
    check("alarm", 32'(b1.alarm), 32'(e_alarm));
    check("persist_cnt", 32'(b1.persist_cnt), 32'(run));
  end
  task automatic drive(logic v, logic [8:0] d, logic [2:0] l, logic [2:0] h, logic [1:0] mv);
    @(negedge clk);
    b1.in_valid = v;
    b1.in_data = d;
    b1.lo = l;
    b1.hi = h;
    b1.min_votes = mv;
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
    end
  endtask
  task automatic beat_chk(string n, logic [8:0] d, logic [2:0] l, logic [2:0] h, logic [1:0] mv,
                          logic [2:0] xm, int xc, logic xh, logic xa, int xp);
    drive(1'b1, d, l, h, mv);
    idle(1);
    @(negedge clk);
    check({n, ".ov"}, 32'(b1.out_valid), 32'd1);
    check({n, ".mask"}, 32'(b1.match_mask), 32'(xm));
    check({n, ".cnt"}, 32'(b1.hit_count), 32'(xc));
    check({n, ".hit"}, 32'(b1.hit), 32'(xh));
    check({n, ".alarm"}, 32'(b1.alarm), 32'(xa));
    check({n, ".pcnt"}, 32'(b1.persist_cnt), 32'(xp));
  endtask
  localparam logic [8:0] HD = {3'd0, 3'd4, 3'd3};
  initial begin
    b1.in_valid = 1'b0;
    b1.in_data = '0;
    b1.lo = '0;
    b1.hi = '0;
    b1.min_votes = '0;
    b2.in_valid = 1'b0;
    b2.in_data = '0;
    b2.lo = '0;
    b2.hi = '0;
    b2.min_votes = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.ov", 32'(b1.out_valid), 32'd0);
    check("rst.alarm", 32'(b1.alarm), 32'd0);
    check("rst.pcnt", 32'(b1.persist_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat_chk("legacy", HD, 3'd3, 3'd4, 2'd2, 3'b011, 2, 1'b1, 1'b0, 1);
    beat_chk("miss", 9'd0, 3'd3, 3'd4, 2'd2, 3'b000, 0, 1'b0, 1'b0, 0);
    beat_chk("empty_win", {3'd5, 3'd4, 3'd3}, 3'd5, 3'd2, 2'd2, 3'b000, 0, 1'b0, 1'b0, 0);
    beat_chk("exact", 9'h1ff, 3'd7, 3'd7, 2'd2, 3'b111, 3, 1'b1, 1'b0, 1);
    beat_chk("mv0", 9'd0, 3'd3, 3'd4, 2'd0, 3'b000, 0, 1'b1, 1'b0, 2);
    beat_chk("mv3", HD, 3'd3, 3'd4, 2'd3, 3'b011, 2, 1'b0, 1'b0, 0);
    for (int i = 0; i < 512; i++) drive(1'b1, 9'(i), 3'd3, 3'd4, 2'd2);
    idle(3);
    for (int k = 0; k < 5; k++) begin
      beat_chk("persist", HD, 3'd3, 3'd4, 2'd2, 3'b011, 2, 1'b1, k >= 3, (k < 4) ? k + 1 : 4);
      idle(1);
    end
    beat_chk("persist_miss", 9'd0, 3'd3, 3'd4, 2'd2, 3'b000, 0, 1'b0, 1'b0, 0);
    repeat (4) drive(1'b1, HD, 3'd3, 3'd4, 2'd2);
    idle(1);
    @(negedge clk);
    check("pre_rst.alarm", 32'(b1.alarm), 32'd1);
    check("pre_rst.pcnt", 32'(b1.persist_cnt), 32'd4);
    drive(1'b1, HD, 3'd3, 3'd4, 2'd2);
    drive(1'b1, HD, 3'd3, 3'd4, 2'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.ov", 32'(b1.out_valid), 32'd0);
    check("mid_rst.mask", 32'(b1.match_mask), 32'd0);
    check("mid_rst.cnt", 32'(b1.hit_count), 32'd0);
    check("mid_rst.hit", 32'(b1.hit), 32'd0);
    check("mid_rst.alarm", 32'(b1.alarm), 32'd0);
    check("mid_rst.pcnt", 32'(b1.persist_cnt), 32'd0);
    b1.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst.ov", 32'(b1.out_valid), 32'd0);
    end
    beat_chk("post_rst", HD, 3'd3, 3'd4, 2'd2, 3'b011, 2, 1'b1, 1'b0, 1);
    @(negedge clk);
    b2.lo = 8'd100;
    b2.hi = 8'd200;
    b2.min_votes = 3'd3;
    b2.in_data = {8'd201, 8'd200, 8'd150, 8'd100, 8'd99};
    b2.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b2.in_valid = 1'b0;
    check("gen.ov", 32'(b2.out_valid), 32'd1);
    check("gen.mask", 32'(b2.match_mask), 32'b01110);
    check("gen.cnt", 32'(b2.hit_count), 32'd3);
    check("gen.hit", 32'(b2.hit), 32'd1);
    check("gen.alarm1", 32'(b2.alarm), 32'd0);
    check("gen.pcnt1", 32'(b2.persist_cnt), 32'd1);
    @(negedge clk);
    check("gen.alarm2", 32'(b2.alarm), 32'd1);
    check("gen.pcnt2", 32'(b2.persist_cnt), 32'd2);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
